au_add_pipe: RTL and testbench
==============================

# AU_add_pipe

Pipelined, parametrised binary adder/subtractor for the arithmetic-unit library. It splits a WIDTH-bit add into NS carry-chained segments, one per register stage, and adds valid/ready flow control, per-transaction subtract mode and a signed-overflow flag. It is the throughput-oriented successor to the single-cycle fast-carry adder. It sits between operand producers and result consumers, which may stall it.

## Interface
- WIDTH, 16: operand/sum word length (>= 1).
- STAGES, 4: requested pipeline depth, 1..WIDTH.
  - Segment width SEG = ceil(WIDTH/STAGES).
  - Effective depth NS = ceil(WIDTH/SEG).
- ARCH, 0: prefix-network architecture (0 to 2) used inside each segment adder.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand transaction offered.
- in_ready  output  1  block accepts the transaction this cycle.
- a  input  WIDTH  augend / minuend.
- b  input  WIDTH  addend / subtrahend.
- ci  input  1  carry-in (add) or borrow-in (subtract).
- sub  input  1  0: add, 1: subtract.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts the result.
- s  output  WIDTH  sum/difference, modulo 2^WIDTH.
- co  output  1  carry-out of the internal addition (subtract: 1 = no borrow).
- ov  output  1  two's-complement signed overflow.

## Operation
- Operand preparation at accept:
  - b' = sub ? ~b : b.
  - c0 = sub ? ~ci : ci.
  - Result is a + b' + c0. Subtract therefore gives a − b − ci.
- Segment k (0..NS−1) covers bits [k·SEG, min((k+1)·SEG, WIDTH)−1]. The last segment may be narrower.
- Stage k adds segment k, using the carry registered by stage k−1 (stage 0 uses c0).
- Skew registers carry the not-yet-added operand segments forward. Deskew registers hold the finished sum segments, so all of s leaves together.
- co = carry out of segment NS−1. ov = carry into MSB XOR carry out of MSB, both taken from the prepared operands.
- Flow control:
  - Global advance signal: adv = !out_valid || out_ready.
  - in_ready = adv.
  - A transfer occurs on in_valid && in_ready.
  - While adv=0, every stage register holds, including valid bits and data.
  - While adv=1, each stage valid bit loads the valid bit of the stage before it; stage 0 loads in_valid && in_ready.
  - Bubbles are not collapsed. A bubble advances like data.
- Results are emitted in acceptance order. No transaction is dropped or duplicated.
- When out_valid=1 and out_ready=0, s/co/ov are held stable until the transfer completes.

## Timing
- Latency: a transaction accepted at edge t presents out_valid=1 with its result after edge t+NS−1.
  - NS=1 means the result is visible in the cycle following acceptance.
- Throughput: one transaction per cycle when out_ready is held at 1.
- Reset (rst=1 at an edge):
  - All stage valid bits clear, so out_valid=0.
  - s=0, co=0, ov=0. All data registers are zero.
  - in_ready=1 during and after reset, since adv=1 when out_valid=0.
- Reset mid-operation: every in-flight transaction is discarded. A transaction offered in the same cycle as rst=1 is not accepted.
- Full pipeline with out_ready=0: in_ready=0, so the producer must hold its operands.
- Simultaneous output transfer and input accept in the same cycle is legal; occupancy is unchanged.
- Degenerate cases:
  - WIDTH=1 gives NS=1.
  - STAGES > WIDTH is illegal; elaboration-time error.

## Test plan
- Add, WIDTH=8, STAGES=2 (NS=2), in_valid pulse with a=0xFF, b=0x01, ci=0, sub=0 -> after 2 edges: s=0x00, co=1, ov=0, out_valid=1 for exactly one cycle with out_ready=1.
- Subtract, WIDTH=8, STAGES=2: a=0x80, b=0x01, ci=0, sub=1 -> s=0x7F, co=1, ov=1. Second transaction a=0x00, b=0x01, ci=1, sub=1 -> s=0xFE, co=0, ov=0.
- Back-to-back stream, WIDTH=16, STAGES=4, out_ready=1, 1000 random operand/mode/ci transactions:
  - Outputs match reference a±b±ci in order with latency 4.
  - One result per cycle.
- Backpressure: hold out_ready=0 with pipeline full -> in_ready=0, and s/co/ov/out_valid remain stable for 10 cycles. Release with random out_ready -> no loss or duplication versus the scoreboard.
- Reset mid-stream: assert rst with 3 transactions in flight -> next cycle out_valid=0, s=0, co=0, ov=0, in_ready=1. A fresh transaction 0x1234+0x4321 yields s=0x5555 after NS edges.
- Uneven segments, WIDTH=7, STAGES=3 (SEG=3, NS=3, segments 3/3/1): a=0x7F, b=0x01, ci=1 -> s=0x01, co=1, ov=0 after 3 edges.

Source files
------------

// File: rtl/au_add_pipe.sv
// Pipelined adder/subtractor: WIDTH-bit add split into NS carry-chained
// segments, one per register stage, under a single global advance.
module au_add_pipe #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4,
  parameter int ARCH   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ov
);

  localparam int SEG = (WIDTH + STAGES - 1) / STAGES;
  localparam int NS  = (WIDTH + SEG - 1) / SEG;
  localparam int W1  = WIDTH + 1;

  typedef logic [WIDTH-1:0] word_t;

  if (WIDTH < 1 || STAGES < 1 || STAGES > WIDTH ||
      ARCH < 0 || ARCH > 2) begin : g_bad_params
    $error("au_add_pipe: illegal WIDTH/STAGES/ARCH");
  end

  logic  vld_q [NS];
  word_t a_q   [NS];
  word_t b_q   [NS];
  word_t s_q   [NS];
  logic  c_q   [NS];
  logic  ov_q;

  word_t ia [NS];
  word_t ib [NS];
  word_t is [NS];
  logic  ic [NS];
  logic  iv [NS];
  word_t s_d [NS];
  logic  c_d [NS];
  logic  ov_d;
  logic  adv;

  word_t       m;
  logic [W1-1:0] t;
  logic [W1-1:0] cm;
  int          top;

  // Stage inputs: stage 0 takes prepared operands, later stages the skew regs
  always_comb begin
    adv   = !vld_q[NS-1] || out_ready;
    ia[0] = a;
    ib[0] = sub ? ~b : b;
    ic[0] = sub ^ ci;
    is[0] = '0;
    iv[0] = in_valid && adv;
    for (int k = 1; k < NS; k++) begin
      ia[k] = a_q[k-1];
      ib[k] = b_q[k-1];
      ic[k] = c_q[k-1];
      is[k] = s_q[k-1];
      iv[k] = vld_q[k-1];
    end
  end

  always_comb begin
    m    = '0;
    t    = '0;
    cm   = '0;
    top  = 0;
    ov_d = 1'b0;
    for (int k = 0; k < NS; k++) begin
      top = (k + 1) * SEG;
      if (top > WIDTH) top = WIDTH;
      for (int i = 0; i < WIDTH; i++)
        m[i] = (i >= k * SEG) && (i < top);
      t = {1'b0, ia[k] & m} + {1'b0, ib[k] & m}
        + (W1'(ic[k]) << (k * SEG));
      cm     = W1'(1) << top;
      s_d[k] = (is[k] & ~m) | (t[WIDTH-1:0] & m);
      c_d[k] = |(t & cm);
    end
    // carry into MSB recovered as a^b^s at that bit
    ov_d = c_d[NS-1] ^ ia[NS-1][WIDTH-1]
         ^ ib[NS-1][WIDTH-1] ^ s_d[NS-1][WIDTH-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NS; k++) begin
        vld_q[k] <= 1'b0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        s_q[k]   <= '0;
        c_q[k]   <= 1'b0;
      end
      ov_q <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < NS; k++) begin
        vld_q[k] <= iv[k];
        a_q[k]   <= ia[k];
        b_q[k]   <= ib[k];
        s_q[k]   <= s_d[k];
        c_q[k]   <= c_d[k];
      end
      ov_q <= ov_d;
    end
  end

  assign in_ready  = adv;
  assign out_valid = vld_q[NS-1];
  assign s         = s_q[NS-1];
  assign co        = c_q[NS-1];
  assign ov        = ov_q;

endmodule

// File: tb/tb_au_add_pipe.sv
// Directed bench for au_add_pipe: three geometries (8/2, 16/4, 7/3)
// sharing one clock and reset.
module tb_au_add_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic       iv8, ir8, ci8, sb8, v8, or8, co8, ov8;
  logic [7:0] a8, b8, s8;
  logic        iv16, ir16, ci16, sb16, v16, or16, co16, ov16;
  logic [15:0] a16, b16, s16;
  logic       iv7, ir7, ci7, sb7, v7, or7, co7, ov7;
  logic [6:0] a7, b7, s7;

  logic [17:0] q[$];

  au_add_pipe #(.WIDTH(8), .STAGES(2), .ARCH(0)) u8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8),
    .a(a8), .b(b8), .ci(ci8), .sub(sb8), .out_valid(v8),
    .out_ready(or8), .s(s8), .co(co8), .ov(ov8));

  au_add_pipe #(.WIDTH(16), .STAGES(4), .ARCH(1)) u16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16),
    .a(a16), .b(b16), .ci(ci16), .sub(sb16), .out_valid(v16),
    .out_ready(or16), .s(s16), .co(co16), .ov(ov16));

  au_add_pipe #(.WIDTH(7), .STAGES(3), .ARCH(2)) u7 (
    .clk(clk), .rst(rst), .in_valid(iv7), .in_ready(ir7),
    .a(a7), .b(b7), .ci(ci7), .sub(sb7), .out_valid(v7),
    .out_ready(or7), .s(s7), .co(co7), .ov(ov7));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One 16-bit cycle: random operands, check/pop on output transfer,
  // push the reference result on input transfer.
  task automatic cyc16(input bit iv, input bit ordy);
    logic [16:0] r;
    logic [15:0] bb;
    logic        c0, ovm, acc;
    logic [17:0] e;
    iv16 = iv;
    or16 = ordy;
    a16  = 16'($urandom);
    b16  = 16'($urandom);
    ci16 = 1'($urandom_range(0, 1));
    sb16 = 1'($urandom_range(0, 1));
    #1;
    acc = iv16 && ir16;
    if (v16 && or16) begin
      if (q.size() == 0) chk("sb_empty", 32'(q.size()), 32'd1);
      else begin
        e = q.pop_front();
        chk("stream16", 32'({ov16, co16, s16}), 32'(e));
      end
    end
    bb  = sb16 ? ~b16 : b16;
    c0  = sb16 ? ~ci16 : ci16;
    r   = {1'b0, a16} + {1'b0, bb} + 17'(c0);
    ovm = (a16[15] == bb[15]) && (r[15] != a16[15]);
    tick();
    if (acc) q.push_back({ovm, r[16], r[15:0]});
  endtask

  task automatic drain16;
    for (int i = 0; i < 60 && q.size() > 0; i++) cyc16(1'b0, 1'b1);
    chk("drain_empty", 32'(q.size()), 32'd0);
  endtask

  initial begin
    iv8 = 0; a8 = 0; b8 = 0; ci8 = 0; sb8 = 0; or8 = 1;
    iv16 = 0; a16 = 0; b16 = 0; ci16 = 0; sb16 = 0; or16 = 1;
    iv7 = 0; a7 = 0; b7 = 0; ci7 = 0; sb7 = 0; or7 = 1;
    tick();
    tick();
    chk("rst_valid", 32'(v8), 32'd0);
    chk("rst_ready", 32'(ir8), 32'd1);
    chk("rst_out16", 32'({ov16, co16, s16}), 32'd0);
    rst = 1'b0;

    // 8-bit add wrap
    iv8 = 1; a8 = 8'hFF; b8 = 8'h01; ci8 = 0; sb8 = 0;
    tick();
    iv8 = 0;
    chk("add8_early", 32'(v8), 32'd0);
    tick();
    chk("add8_valid", 32'(v8), 32'd1);
    chk("add8_res", 32'({ov8, co8, s8}), {22'd0, 1'b0, 1'b1, 8'h00});
    tick();
    chk("add8_once", 32'(v8), 32'd0);

    // 8-bit subtract pair, back to back
    iv8 = 1; a8 = 8'h80; b8 = 8'h01; ci8 = 0; sb8 = 1;
    tick();
    a8 = 8'h00; b8 = 8'h01; ci8 = 1; sb8 = 1;
    tick();
    iv8 = 0;
    chk("sub8_a", 32'({v8, ov8, co8, s8}), {21'd0, 3'b111, 8'h7F});
    tick();
    chk("sub8_b", 32'({v8, ov8, co8, s8}), {21'd0, 3'b100, 8'hFE});

    // 7-bit uneven segments
    iv7 = 1; a7 = 7'h7F; b7 = 7'h01; ci7 = 1; sb7 = 0;
    tick();
    iv7 = 0;
    tick();
    chk("add7_early", 32'(v7), 32'd0);
    tick();
    chk("add7_res", 32'({v7, ov7, co7, s7}), {22'd0, 3'b101, 7'h01});

    // 16-bit stream, latency 4, one result per cycle
    for (int i = 0; i < 1000; i++) begin
      if (i < 8 || i % 100 == 0)
        chk("lat16", 32'(v16), (i >= 4) ? 32'd1 : 32'd0);
      cyc16(1'b1, 1'b1);
    end
    chk("inflight16", 32'(q.size()), 32'd4);
    drain16();

    // backpressure: fill, then hold 10 cycles
    for (int i = 0; i < 6; i++) cyc16(1'b1, 1'b0);
    chk("full_count", 32'(q.size()), 32'd4);
    chk("full_ready", 32'(ir16), 32'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_flags", 32'({v16, ir16}), 32'b10);
      chk("hold_data", 32'({ov16, co16, s16}), 32'(q[0]));
    end
    for (int i = 0; i < 300; i++)
      cyc16(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    drain16();

    // reset with three in flight; offer in the reset cycle too
    iv16 = 1; or16 = 1; sb16 = 0; ci16 = 0;
    for (int i = 0; i < 3; i++) begin
      a16 = 16'(i + 1);
      b16 = 16'hFF00;
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    iv16 = 0;
    chk("mrst_out", 32'({v16, ov16, co16, s16}), 32'd0);
    chk("mrst_ready", 32'(ir16), 32'd1);
    q.delete();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mrst_quiet", 32'(v16), 32'd0);
    end
    iv16 = 1; a16 = 16'h1234; b16 = 16'h4321; ci16 = 0; sb16 = 0;
    tick();
    iv16 = 0;
    tick();
    tick();
    chk("fresh_early", 32'(v16), 32'd0);
    tick();
    chk("fresh_res", 32'({v16, ov16, co16, s16}), {13'd0, 3'b100, 16'h5555});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
